// File: rtl/vx_dispatch_arb.sv
// vx_dispatch_arb: per-(slot,unit) FIFOs drained into per-unit output registers by round-robin over slots.
// Optional per-unit stall counters (perf_stalls) are built when DISPATCH_PERF_EN is defined.
module vx_dispatch_arb #(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NT      = 4,
  parameter int unsigned DATAW   = 64,
  localparam int unsigned UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
  localparam int unsigned SW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int unsigned TW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_IN-1:0]                 in_valid,
  output logic [N_IN-1:0]                 in_ready,
  input  logic [N_IN-1:0][UW-1:0]         in_ex_type,
  input  logic [N_IN-1:0][NT-1:0]         in_tmask,
  input  logic [N_IN-1:0][DATAW-1:0]      in_data,
  output logic [N_UNITS-1:0]              out_valid,
  input  logic [N_UNITS-1:0]              out_ready,
  output logic [N_UNITS-1:0][DATAW-1:0]   out_data,
  output logic [N_UNITS-1:0][NT-1:0]      out_tmask,
  output logic [N_UNITS-1:0][TW-1:0]      out_tid,
  output logic [N_UNITS-1:0][SW-1:0]      out_src
`ifdef DISPATCH_PERF_EN
  ,
  output logic [N_UNITS-1:0][31:0]        perf_stalls
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [NT-1:0]    tmask;
    logic [TW-1:0]    tid;
  } entry_t;

  entry_t                     mem   [N_IN][N_UNITS][DEPTH];
  logic [AW-1:0]              wptr  [N_IN][N_UNITS];
  logic [AW-1:0]              rptr  [N_IN][N_UNITS];
  logic [CW-1:0]              count [N_IN][N_UNITS];
  logic [N_IN-1:0][N_UNITS-1:0] push;
  logic [N_IN-1:0][N_UNITS-1:0] pop;
  logic [N_UNITS-1:0]         load;
  logic [N_UNITS-1:0]         gnt_valid;
  logic [SW-1:0]              gnt_idx    [N_UNITS];
  logic [SW-1:0]              last_grant [N_UNITS];
  entry_t                     head       [N_UNITS];

  // Highest set thread index; an empty mask maps to thread 0.
  function automatic logic [TW-1:0] hi_bit(input logic [NT-1:0] m);
    logic [TW-1:0] r;
    r = '0;
    for (int b = 0; b < int'(NT); b++) begin
      if (m[b]) r = TW'(b);
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] rr_slot(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= int'(N_IN)) s = s - int'(N_IN);
    return SW'(s);
  endfunction

  // Ready reflects only the target FIFO's occupancy; a same-cycle pop does not free a slot.
  always_comb begin
    in_ready = '0;
    push     = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        if (in_ex_type[i] == UW'(u)) begin
          in_ready[i]   = count[i][u] < CW'(DEPTH);
          push[i][u]    = in_valid[i] && (count[i][u] < CW'(DEPTH));
        end
      end
    end
  end

  // Descending scan so the nearest non-empty slot after last_grant wins.
  always_comb begin
    load      = '0;
    gnt_valid = '0;
    pop       = '0;
    for (int u = 0; u < int'(N_UNITS); u++) begin
      gnt_idx[u] = '0;
      head[u]    = '0;
    end
    for (int u = 0; u < int'(N_UNITS); u++) begin
      load[u] = !out_valid[u] || out_ready[u];
      for (int k = int'(N_IN); k >= 1; k--) begin
        if (count[rr_slot(last_grant[u], k)][u] != '0) begin
          gnt_valid[u] = 1'b1;
          gnt_idx[u]   = rr_slot(last_grant[u], k);
        end
      end
      head[u] = mem[gnt_idx[u]][u][rptr[gnt_idx[u]][u]];
      for (int i = 0; i < int'(N_IN); i++) begin
        pop[i][u] = load[u] && gnt_valid[u] && (gnt_idx[u] == SW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        for (int u = 0; u < int'(N_UNITS); u++) begin
          count[i][u] <= '0;
          wptr[i][u]  <= '0;
          rptr[i][u]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        for (int u = 0; u < int'(N_UNITS); u++) begin
          count[i][u] <= count[i][u] + CW'(push[i][u]) - CW'(pop[i][u]);
          wptr[i][u]  <= wptr[i][u] + AW'(push[i][u]);
          rptr[i][u]  <= rptr[i][u] + AW'(pop[i][u]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_IN); i++) begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        if (push[i][u]) begin
          mem[i][u][wptr[i][u]] <= '{data: in_data[i], tmask: in_tmask[i], tid: hi_bit(in_tmask[i])};
        end
      end
    end
  end

  // Per-unit holding register; payload keeps its last value when the unit goes idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
      out_data  <= '0;
      out_tmask <= '0;
      out_tid   <= '0;
      out_src   <= '0;
      for (int u = 0; u < int'(N_UNITS); u++) begin
        last_grant[u] <= SW'(N_IN - 1);
      end
    end else begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        if (load[u]) begin
          out_valid[u] <= gnt_valid[u];
          if (gnt_valid[u]) begin
            out_data[u]   <= head[u].data;
            out_tmask[u]  <= head[u].tmask;
            out_tid[u]    <= head[u].tid;
            out_src[u]    <= gnt_idx[u];
            last_grant[u] <= gnt_idx[u];
          end
        end
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [N_UNITS-1:0] stall_any;

  always_comb begin
    stall_any = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        if (in_valid[i] && !in_ready[i] && (in_ex_type[i] == UW'(u))) stall_any[u] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stalls <= '0;
    end else begin
      for (int u = 0; u < int'(N_UNITS); u++) begin
        perf_stalls[u] <= perf_stalls[u] + 32'(stall_any[u]);
      end
    end
  end
`endif

endmodule
